// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter for an ALU and a long-latency writeback source,
// with a destination-register scoreboard that stalls dispatch on RAW/WAW hazards.
module regfile_wb_arbiter #(
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [4:0]  s0_rd,
    input  logic [31:0] s0_data,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [4:0]  s1_rd,
    input  logic [31:0] s1_data,
    input  logic        issue_valid,
    input  logic        issue_long,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    output logic        stall,
    output logic        we,
    output logic [4:0]  rd,
    output logic [31:0] rd_data,
    output logic [31:0] busy
);

    localparam int unsigned RW   = 5;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    logic             we_q, we_d;
    logic [RW-1:0]    rd_q, rd_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;

    logic grant0, grant1;
    logic h1, h2, h3, full;
    logic sb_set, sb_clr;

    // Round-robin grant; last_grant_q=1 means source 1 won the previous transfer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rstn) begin
            grant0 = s0_valid && (!s1_valid || last_grant_q);
            grant1 = s1_valid && (!s0_valid || !last_grant_q);
        end
    end

    assign s0_ready = grant0;
    assign s1_ready = grant1;

    // Hazard detection uses only registered scoreboard state, never the same-cycle writeback.
    always_comb begin
        h1    = (issue_rs1 != RW'(0)) && busy_q[issue_rs1];
        h2    = (issue_rs2 != RW'(0)) && busy_q[issue_rs2];
        h3    = (issue_rd  != RW'(0)) && busy_q[issue_rd];
        full  = issue_long && (cnt_q == CNT_W'(MAX_PENDING));
        stall = issue_valid && (h1 || h2 || h3 || full);
    end

    // Scoreboard update: clear first, then set, so a new owner of the same register wins.
    always_comb begin
        sb_set = issue_valid && issue_long && !stall && (issue_rd != RW'(0));
        sb_clr = grant1 && (s1_rd != RW'(0)) && busy_q[s1_rd]
                 && !(sb_set && (issue_rd == s1_rd));
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (sb_clr) begin
            busy_d[s1_rd] = 1'b0;
        end
        if (sb_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (sb_set && !sb_clr) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!sb_set && sb_clr) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Write-port staging; x0 targets are accepted but never written.
    always_comb begin
        we_d         = 1'b0;
        rd_d         = rd_q;
        rd_data_d    = rd_data_q;
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
            if (s0_rd != RW'(0)) begin
                we_d      = 1'b1;
                rd_d      = s0_rd;
                rd_data_d = s0_data;
            end
        end else if (grant1) begin
            last_grant_d = 1'b1;
            if (s1_rd != RW'(0)) begin
                we_d      = 1'b1;
                rd_d      = s1_rd;
                rd_data_d = s1_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            we_q         <= 1'b0;
            rd_q         <= RW'(0);
            rd_data_q    <= XLEN'(0);
            busy_q       <= NREG'(0);
            cnt_q        <= CNT_W'(0);
            last_grant_q <= 1'b1;
        end else begin
            we_q         <= we_d;
            rd_q         <= rd_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign we      = we_q;
    assign rd      = rd_q;
    assign rd_data = rd_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued when a transfer
// is driven and matched against the write port one cycle later.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_rd, s1_rd;
    logic [31:0] s0_data, s1_data;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        stall;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [31:0] busy;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   cyc_n;
    logic mlg;

    regfile_wb_arbiter #(.MAX_PENDING(4), .CNT_W(3)) dut (
        .clk(clk), .rstn(rstn),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
        .issue_valid(issue_valid), .issue_long(issue_long),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .stall(stall), .we(we), .rd(rd), .rd_data(rd_data), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock; afterwards the write port is matched against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        if (sb.size() != 0 && sb[0].due == cyc_n) begin
            e = sb.pop_front();
            chk("wb_we", 32'(we), 32'd1);
            chk("wb_rd", 32'(rd), 32'(e.rd));
            chk("wb_data", rd_data, e.data);
        end else begin
            chk("wb_idle_we", 32'(we), 32'd0);
        end
    endtask

    task automatic issue(input logic v, input logic lng, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rdd);
        issue_valid = v;
        issue_long  = lng;
        issue_rs1   = r1;
        issue_rs2   = r2;
        issue_rd    = rdd;
    endtask

    // Drive both sources, check grants against a round-robin model, queue the expected write.
    task automatic present(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                           input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        logic g0, g1;
        exp_t e;
        s0_valid = v0; s0_rd = r0; s0_data = d0;
        s1_valid = v1; s1_rd = r1; s1_data = d1;
        #1;
        g0 = v0 && (!v1 || mlg);
        g1 = v1 && (!v0 || !mlg);
        chk("s0_ready", 32'(s0_ready), 32'(g0));
        chk("s1_ready", 32'(s1_ready), 32'(g1));
        if (g0) begin
            mlg = 1'b0;
            if (r0 != 5'd0) begin
                e.due = cyc_n + 1; e.rd = r0; e.data = d0;
                sb.push_back(e);
            end
        end else if (g1) begin
            mlg = 1'b1;
            if (r1 != 5'd0) begin
                e.due = cyc_n + 1; e.rd = r1; e.data = d1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        present(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sb.delete();
        mlg = 1'b1;
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        s0_valid = 1'b0; s1_valid = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; cyc_n = 0; mlg = 1'b1;
        rstn = 1'b0;
        s0_valid = 1'b0; s0_rd = 5'd0; s0_data = 32'd0;
        s1_valid = 1'b0; s1_rd = 5'd0; s1_data = 32'd0;
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        rstn = 1'b1;

        // Conflict right after reset: s0 wins first, then strict alternation.
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 5'd1, 32'hA1A1_0001, 1'b1, 5'd2, 32'hB2B2_0002);
            step();
        end
        idle();
        step();

        // Single transfer and hold of rd/rd_data afterwards.
        present(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        step();
        idle();
        step();
        chk("hold_rd", 32'(rd), 32'd5);
        chk("hold_data", rd_data, 32'hDEAD_BEEF);

        // RAW on x7 owned by a long op.
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd7);
        idle();
        chk("raw_issue_stall", 32'(stall), 32'd0);
        step();
        chk("raw_busy_set", busy, 32'h0000_0080);
        issue(1'b1, 1'b0, 5'd7, 5'd0, 5'd8);
        idle();
        chk("raw_stall", 32'(stall), 32'd1);
        step();
        present(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0777);
        chk("raw_stall_same_cycle", 32'(stall), 32'd1);
        step();
        idle();
        chk("raw_stall_released", 32'(stall), 32'd0);
        chk("raw_busy_clear", busy, 32'd0);

        // x0 never tracked nor written.
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        idle();
        chk("x0_issue_stall", 32'(stall), 32'd0);
        step();
        chk("x0_busy", busy, 32'd0);
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        present(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        step();

        // Capacity: four outstanding long ops fill the scoreboard.
        for (int r = 1; r <= 4; r++) begin
            issue(1'b1, 1'b1, 5'd0, 5'd0, 5'(r));
            idle();
            chk("cap_fill_stall", 32'(stall), 32'd0);
            step();
        end
        chk("cap_busy", busy, 32'h0000_001E);
        issue(1'b1, 1'b0, 5'd0, 5'd3, 5'd0);
        idle();
        chk("h2_stall", 32'(stall), 32'd1);
        issue(1'b1, 1'b0, 5'd0, 5'd0, 5'd9);
        idle();
        chk("full_short_nostall", 32'(stall), 32'd0);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd9);
        idle();
        chk("full_stall", 32'(stall), 32'd1);
        step();
        chk("full_busy_hold", busy, 32'h0000_001E);
        present(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_0444);
        chk("full_stall_clear_cycle", 32'(stall), 32'd1);
        step();
        idle();
        chk("full_stall_drop", 32'(stall), 32'd0);
        step();
        chk("full_busy_after", busy, 32'h0000_020E);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd10);
        idle();
        chk("full_again", 32'(stall), 32'd1);

        // Same-cycle set and clear: different registers, then the same register.
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        present(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0999);
        step();
        chk("sc_busy0", busy, 32'h0000_000E);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd5);
        present(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h0000_0111);
        chk("sc_diff_stall", 32'(stall), 32'd0);
        step();
        chk("sc_diff_busy", busy, 32'h0000_002C);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
        idle();
        chk("sc_cnt_kept", 32'(stall), 32'd0);
        step();
        chk("sc_busy_x6", busy, 32'h0000_006C);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd10);
        idle();
        chk("sc_full", 32'(stall), 32'd1);
        step();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        present(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_0666);
        step();
        chk("sc_busy_drop6", busy, 32'h0000_002C);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd3);
        present(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0333);
        chk("sc_waw_stall", 32'(stall), 32'd1);
        step();
        chk("sc_x3_cleared", busy, 32'h0000_0024);
        present(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_3333);
        chk("sc_same_stall", 32'(stall), 32'd0);
        step();
        chk("sc_same_owner", busy, 32'h0000_002C);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
        idle();
        chk("sc_cnt3_nostall", 32'(stall), 32'd0);
        step();
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd10);
        idle();
        chk("sc_cnt4_full", 32'(stall), 32'd1);

        // Reset mid-flight with x1..x4 owned and a pending s0 request.
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            issue(1'b1, 1'b1, 5'd0, 5'd0, 5'(r));
            idle();
            step();
        end
        chk("mid_busy_pre", busy, 32'h0000_001E);
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        rstn = 1'b0;
        s0_valid = 1'b1; s0_rd = 5'd12; s0_data = 32'hCAFE_F00D;
        sb.delete();
        mlg = 1'b1;
        step();
        chk("mid_busy", busy, 32'd0);
        rstn = 1'b1;
        s0_valid = 1'b0;
        issue(1'b1, 1'b1, 5'd1, 5'd0, 5'd20);
        idle();
        chk("mid_cnt_cleared", 32'(stall), 32'd0);
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
